// File: rtl/pattern_ram_emulator_if.sv
// Framebuffer read port between the display driver chain and the emulated RAM.
// One address per cycle, pixel data returned a fixed number of cycles later.
interface pattern_ram_emulator_if;
    logic [31:0] r_addr;
    logic [15:0] r_data;

    modport master (output r_addr, input r_data);
    modport slave  (input r_addr, output r_data);
endinterface

// File: rtl/pattern_ram_emulator.sv
// Synthetic framebuffer RAM: answers reads with RGB565 test patterns driven by a stepping head.
// Optional build macro PATTERN_RAM_SLICE_SKEW_EN offsets the head per slice in modes 0 and 3.
module pattern_ram_emulator #(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 48,
    parameter int unsigned SLICES       = 1,
    parameter int unsigned TAIL         = 8,
    parameter int unsigned AUTO_PERIOD  = 66_000_000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned SLICE_SKEW   = 40
) (
    input  logic                         clk,
    input  logic                         nrst,
    pattern_ram_emulator_if.slave        bus,
    input  logic [1:0]                   mode,
    input  logic                         step_n,
    input  logic                         auto_en,
    output logic [31:0]                  pixel_index,
    output logic                         frame_wrap
);

    localparam int unsigned N           = COLS * ROWS;
    localparam logic [31:0] N_W         = 32'(N);
    localparam logic [31:0] LAST_W      = 32'(N - 1);
    localparam logic [31:0] SPAN_W      = 32'(N * SLICES);
    localparam logic [31:0] COLS_W      = 32'(COLS);
    localparam logic [31:0] TAIL_MAX_W  = 32'(TAIL - 1);
    localparam logic [31:0] AUTO_LAST_W = 32'(AUTO_PERIOD - 1);
    localparam int          LAT         = (READ_LATENCY >= 2) ? 2 : 1;

    localparam logic [15:0] PIX_BLACK = 16'h0000;
    localparam logic [15:0] PIX_WHITE = 16'hFFFF;
    localparam logic [15:0] PIX_GREEN = 16'h07E0;
    localparam logic [15:0] PIX_RED   = 16'hF800;
    localparam logic [15:0] PIX_BLUE  = 16'h001F;

    logic [31:0] pixel_index_r;
    logic        frame_wrap_r;
    logic [31:0] auto_cnt_r;
    logic [1:0]  mode_r;
    logic [1:0]  step_sync_r;
    logic [1:0]  sync_fill_r;
    logic        step_prev_r;
    logic [15:0] pipe_r [LAT];

    logic [31:0] p_s;
    logic [31:0] row_s;
    logic [31:0] col_s;
    logic [31:0] head_s;
    logic [31:0] head_col_s;
    logic [31:0] diff_s;
    logic        addr_ok_s;
    logic [15:0] pix_s;
    logic        step_pulse_s;
    logic        auto_pulse_s;
    logic        advance_s;
    logic        mode_change_s;

`ifdef PATTERN_RAM_SLICE_SKEW_EN
    localparam logic [31:0] SKEW_W = 32'(SLICE_SKEW % N);
    logic [31:0] slice_s;
    logic [31:0] skew_s;
    logic [31:0] skew_sum_s;
`endif

    // Address decode and pattern generation for the address presented this cycle.
    always_comb begin
        p_s       = bus.r_addr % N_W;
        row_s     = p_s / COLS_W;
        col_s     = p_s % COLS_W;
        addr_ok_s = (bus.r_addr < SPAN_W);
`ifdef PATTERN_RAM_SLICE_SKEW_EN
        // Each slice's head is advanced by its skew so the slices form a helix.
        slice_s    = bus.r_addr / N_W;
        skew_s     = (slice_s * SKEW_W) % N_W;
        skew_sum_s = pixel_index_r + skew_s;
        if (skew_sum_s >= N_W) begin
            head_s = skew_sum_s - N_W;
        end else begin
            head_s = skew_sum_s;
        end
`else
        head_s = pixel_index_r;
`endif
        head_col_s = head_s % COLS_W;
        // Distance behind the head, kept non-negative across index 0.
        if (head_s >= p_s) begin
            diff_s = head_s - p_s;
        end else begin
            diff_s = head_s + N_W - p_s;
        end

        pix_s = PIX_BLACK;
        if (!addr_ok_s) begin
            pix_s = PIX_BLACK;
        end else begin
            case (mode)
                2'd0: begin
                    if (diff_s == 32'd0) begin
                        pix_s = PIX_WHITE;
                    end else if (diff_s <= TAIL_MAX_W) begin
                        pix_s = PIX_GREEN;
                    end else begin
                        pix_s = PIX_BLACK;
                    end
                end
                2'd1: pix_s = PIX_WHITE;
                2'd2: begin
                    if (((row_s ^ col_s) & 32'd1) != 32'd0) begin
                        pix_s = PIX_RED;
                    end else begin
                        pix_s = PIX_BLACK;
                    end
                end
                2'd3: begin
                    if (col_s == head_col_s) begin
                        pix_s = PIX_BLUE;
                    end else begin
                        pix_s = PIX_BLACK;
                    end
                end
                default: pix_s = PIX_BLACK;
            endcase
        end
    end

    // Read data pipeline; reset flushes anything in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= 16'h0000;
            end
        end else begin
            pipe_r[0] <= pix_s;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i - 1];
            end
        end
    end

    assign bus.r_data = pipe_r[LAT - 1];

    // Button synchroniser; the edge detector is only armed once real samples have filled the chain,
    // so a button held down across reset release never produces a step.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_sync_r <= 2'b11;
            sync_fill_r <= 2'b00;
            step_prev_r <= 1'b0;
        end else begin
            step_sync_r <= {step_sync_r[0], step_n};
            sync_fill_r <= {sync_fill_r[0], 1'b1};
            step_prev_r <= sync_fill_r[1] & step_sync_r[1];
        end
    end

    // Advance requests and mode-change detection.
    always_comb begin
        step_pulse_s  = step_prev_r & ~step_sync_r[1];
        auto_pulse_s  = auto_en && (auto_cnt_r == AUTO_LAST_W);
        advance_s     = step_pulse_s | auto_pulse_s;
        mode_change_s = (mode != mode_r);
    end

    // Head index, auto-advance counter and wrap pulse; a mode change overrides any advance.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_r        <= 2'd0;
            auto_cnt_r    <= 32'd0;
            pixel_index_r <= 32'd0;
            frame_wrap_r  <= 1'b0;
        end else begin
            mode_r <= mode;
            if (mode_change_s) begin
                auto_cnt_r    <= 32'd0;
                pixel_index_r <= 32'd0;
                frame_wrap_r  <= 1'b0;
            end else begin
                if (!auto_en || auto_pulse_s) begin
                    auto_cnt_r <= 32'd0;
                end else begin
                    auto_cnt_r <= auto_cnt_r + 32'd1;
                end
                if (advance_s) begin
                    if (pixel_index_r == LAST_W) begin
                        pixel_index_r <= 32'd0;
                        frame_wrap_r  <= 1'b1;
                    end else begin
                        pixel_index_r <= pixel_index_r + 32'd1;
                        frame_wrap_r  <= 1'b0;
                    end
                end else begin
                    frame_wrap_r <= 1'b0;
                end
            end
        end
    end

    assign pixel_index = pixel_index_r;
    assign frame_wrap  = frame_wrap_r;

endmodule

// File: tb/tb_pattern_ram_emulator.sv
// Bench for pattern_ram_emulator: two instances (read latency 1 and 2) fed identical stimulus,
// reads checked through per-instance scoreboards, state checked at the points of interest.
module tb_pattern_ram_emulator;

    localparam int unsigned COLS        = 40;
    localparam int unsigned ROWS        = 48;
    localparam int unsigned SLICES      = 2;
    localparam int unsigned TAIL        = 8;
    localparam int unsigned AUTO_PERIOD = 4;

`ifdef PATTERN_RAM_SLICE_SKEW_EN
    localparam logic [15:0] EXP_1920 = 16'h0000;
    localparam logic [15:0] EXP_1960 = 16'hFFFF;
    localparam logic [15:0] EXP_3839 = 16'h0000;
`else
    localparam logic [15:0] EXP_1920 = 16'hFFFF;
    localparam logic [15:0] EXP_1960 = 16'h0000;
    localparam logic [15:0] EXP_3839 = 16'h07E0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  mode;
    logic        step_n;
    logic        auto_en;
    logic [31:0] pixel_index;
    logic [31:0] pixel_index2;
    logic        frame_wrap;
    logic        frame_wrap2;

    pattern_ram_emulator_if bus1 ();
    pattern_ram_emulator_if bus2 ();

    pattern_ram_emulator #(
        .COLS(COLS), .ROWS(ROWS), .SLICES(SLICES), .TAIL(TAIL),
        .AUTO_PERIOD(AUTO_PERIOD), .READ_LATENCY(1), .SLICE_SKEW(40)
    ) dut1 (
        .clk(clk), .nrst(nrst), .bus(bus1.slave), .mode(mode), .step_n(step_n),
        .auto_en(auto_en), .pixel_index(pixel_index), .frame_wrap(frame_wrap)
    );

    pattern_ram_emulator #(
        .COLS(COLS), .ROWS(ROWS), .SLICES(SLICES), .TAIL(TAIL),
        .AUTO_PERIOD(AUTO_PERIOD), .READ_LATENCY(2), .SLICE_SKEW(40)
    ) dut2 (
        .clk(clk), .nrst(nrst), .bus(bus2.slave), .mode(mode), .step_n(step_n),
        .auto_en(auto_en), .pixel_index(pixel_index2), .frame_wrap(frame_wrap2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] exp;
        logic [31:0] addr;
    } sb_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [15:0] exp;
    } vec_t;

    sb_t  q1[$];
    sb_t  q2[$];
    vec_t vecs[$];

    int n_cmp    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wrap_cnt = 0;
    int wrap_cnt2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, scoreboard entries that are due get compared.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (frame_wrap)  wrap_cnt++;
        if (frame_wrap2) wrap_cnt2++;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            check($sformatf("rd_lat1 addr %0d", e.addr), {16'h0000, bus1.r_data}, {16'h0000, e.exp});
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            e = q2.pop_front();
            check($sformatf("rd_lat2 addr %0d", e.addr), {16'h0000, bus2.r_data}, {16'h0000, e.exp});
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [15:0] e);
        bus1.r_addr = a;
        bus2.r_addr = a;
        q1.push_back('{due: cyc + 1, exp: e, addr: a});
        q2.push_back('{due: cyc + 2, exp: e, addr: a});
        tick();
    endtask

    task automatic press();
        step_n = 1'b0;
        repeat (10) tick();
        step_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic check_idx(input string name, input logic [31:0] exp);
        check(name, pixel_index, exp);
        check({name, "_lat2"}, pixel_index2, exp);
    endtask

    initial begin
        nrst = 1'b1;
        mode = 2'd0;
        step_n = 1'b1;
        auto_en = 1'b0;
        bus1.r_addr = 32'd0;
        bus2.r_addr = 32'd0;

        // Pattern table, evaluated with the head at 0; mode 0 entries last so the run ends in mode 0.
        vecs.push_back('{2'd1, 32'd5,    16'hFFFF});
        vecs.push_back('{2'd1, 32'd3840, 16'h0000});
        vecs.push_back('{2'd1, 32'd3839, 16'hFFFF});
        vecs.push_back('{2'd2, 32'd1,    16'hF800});
        vecs.push_back('{2'd2, 32'd40,   16'hF800});
        vecs.push_back('{2'd2, 32'd41,   16'h0000});
        vecs.push_back('{2'd2, 32'd0,    16'h0000});
        vecs.push_back('{2'd2, 32'd1921, 16'hF800});
        vecs.push_back('{2'd3, 32'd0,    16'h001F});
        vecs.push_back('{2'd3, 32'd40,   16'h001F});
        vecs.push_back('{2'd3, 32'd1,    16'h0000});
        vecs.push_back('{2'd0, 32'd0,    16'hFFFF});
        vecs.push_back('{2'd0, 32'd1,    16'h0000});
        vecs.push_back('{2'd0, 32'd1919, 16'h07E0});
        vecs.push_back('{2'd0, 32'd1913, 16'h07E0});
        vecs.push_back('{2'd0, 32'd1912, 16'h0000});
        vecs.push_back('{2'd0, 32'd3840, 16'h0000});
        vecs.push_back('{2'd0, 32'd1920, EXP_1920});
        vecs.push_back('{2'd0, 32'd1960, EXP_1960});
        vecs.push_back('{2'd0, 32'd3839, EXP_3839});

        #2 nrst = 1'b0;
        #1;
        check("reset_rdata_lat1", {16'h0000, bus1.r_data}, 32'd0);
        check("reset_rdata_lat2", {16'h0000, bus2.r_data}, 32'd0);
        check_idx("reset_index", 32'd0);
        check("reset_wrap", {31'd0, frame_wrap}, 32'd0);
        repeat (2) tick();
        nrst = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            mode = vecs[i].mode;
            rd(vecs[i].addr, vecs[i].exp);
        end
        tick();
        check_idx("table_index", 32'd0);

        // Button stepping.
        repeat (3) press();
        check_idx("after_3_steps", 32'd3);
        rd(32'd3,    16'hFFFF);
        rd(32'd2,    16'h07E0);
        rd(32'd11,   16'h0000);
        rd(32'd1919, 16'h07E0);
        rd(32'd4,    16'h0000);
        tick();

        // Mode change clears the index without a wrap pulse.
        repeat (2) press();
        check_idx("after_5_steps", 32'd5);
        wrap_cnt = 0;
        wrap_cnt2 = 0;
        mode = 2'd3;
        repeat (2) tick();
        check_idx("mode_change_index", 32'd0);
        check("mode_change_no_wrap", 32'(wrap_cnt + wrap_cnt2), 32'd0);
        press();
        rd(32'd1,    16'h001F);
        rd(32'd41,   16'h001F);
        rd(32'd0,    16'h0000);
        rd(32'd1961, 16'h001F);
        tick();

        // Auto-advance through a full frame, then a step coinciding with an auto pulse.
        mode = 2'd0;
        repeat (2) tick();
        check_idx("mode0_index", 32'd0);
        wrap_cnt = 0;
        wrap_cnt2 = 0;
        auto_en = 1'b1;
        repeat (4 * 1919) tick();
        check_idx("auto_last", 32'd1919);
        check("auto_no_wrap_yet", 32'(wrap_cnt), 32'd0);
        repeat (4) tick();
        check_idx("auto_wrapped", 32'd0);
        check("auto_wrap_pulses", 32'(wrap_cnt), 32'd1);
        check("auto_wrap_pulses_lat2", 32'(wrap_cnt2), 32'd1);
        tick();
        step_n = 1'b0;
        repeat (3) tick();
        check_idx("step_auto_coincide", 32'd1);
        auto_en = 1'b0;
        repeat (10) tick();
        step_n = 1'b1;
        repeat (5) tick();
        check_idx("coincide_settled", 32'd1);

        // Reset in the middle of a read, with the button held down across release.
        mode = 2'd1;
        repeat (2) tick();
        rd(32'd0, 16'hFFFF);
        #2;
        nrst = 1'b0;
        step_n = 1'b0;
        q2.delete();
        #1;
        check("midread_rst_lat1", {16'h0000, bus1.r_data}, 32'd0);
        check("midread_rst_lat2", {16'h0000, bus2.r_data}, 32'd0);
        check_idx("midread_rst_index", 32'd0);
        repeat (3) tick();
        nrst = 1'b1;
        rd(32'd5000, 16'h0000);
        rd(32'd5000, 16'h0000);
        rd(32'd5000, 16'h0000);
        rd(32'd7,    16'hFFFF);
        repeat (20) tick();
        check_idx("held_button_no_step", 32'd0);
        step_n = 1'b1;
        repeat (5) tick();
        check_idx("button_release_no_step", 32'd0);
        check("scoreboard_drained", 32'(q1.size() + q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
